// File: rtl/pipe4_wb.sv
// Write-back stage (PIPE4): registers the PIPE3 bundle, owns HI/LO, drives RF/CP0 write and commit.
// Optional trace ports are enabled with the PIPE4_DEBUG_TRACE_EN macro.
module pipe4_wb #(
    parameter int CTRL_W = 61,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe4_valid_in,
    input  logic [CTRL_W-1:0] pipe4_ctrl_info_in,
    input  logic [DATA_W-1:0] pipe4_data_info_in,
    output logic              pipe4_allow_in,
    input  logic [DATA_W-1:0] cp0_rdata,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              cp0_we,
    output logic [7:0]        cp0_addr,
    output logic [DATA_W-1:0] cp0_wdata,
    output logic              exc_commit,
    output logic              eret_commit,
    output logic [7:0]        exc_vec,
    output logic [DATA_W-1:0] exc_pc,
    output logic              exc_bd,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic [4:0]        wb_dest,
    output logic [DATA_W-1:0] debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    logic              w_eret;
    logic [7:0]        w_exc_vec;
    logic [DATA_W-1:0] w_pc;
    logic [4:0]        w_dest;
    logic              w_btype;
    logic              w_hiwe;
    logic              w_lowe;
    logic              w_cp0we;
    logic [4:0]        w_cp0cs;
    logic [2:0]        w_cp0sel;
    logic [1:0]        w_wbmux;
    logic              w_regwe;
    logic              w_ok;
    logic              w_exc;
    logic              w_rf_we;
    logic [DATA_W-1:0] w_rf_wdata;

    assign w_eret    = r_ctrl[60];
    assign w_exc_vec = r_ctrl[59:52];
    assign w_pc      = r_ctrl[51:20];
    assign w_dest    = r_ctrl[19:15];
    assign w_btype   = r_ctrl[14];
    assign w_hiwe    = r_ctrl[13];
    assign w_lowe    = r_ctrl[12];
    assign w_cp0we   = r_ctrl[11];
    assign w_cp0cs   = r_ctrl[10:6];
    assign w_cp0sel  = r_ctrl[5:3];
    assign w_wbmux   = r_ctrl[2:1];
    assign w_regwe   = r_ctrl[0];

    // Excepting and ERET instructions are stripped of every architectural write.
    assign w_exc   = r_valid & (|w_exc_vec);
    assign w_ok    = r_valid & ~(|w_exc_vec) & ~w_eret;
    assign w_rf_we = w_ok & w_regwe & (w_dest != 5'd0);

    // Pipeline register: valid is re-sampled every cycle, payload only loads on a new offer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= {CTRL_W{1'b0}};
            r_data  <= {DATA_W{1'b0}};
        end else begin
            r_valid <= pipe4_valid_in;
            if (pipe4_valid_in) begin
                r_ctrl <= pipe4_ctrl_info_in;
                r_data <= pipe4_data_info_in;
            end
        end
    end

    // HI/LO land at the end of the writing instruction's WB cycle, so its own read sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= {DATA_W{1'b0}};
            r_lo <= {DATA_W{1'b0}};
        end else begin
            if (w_ok & w_hiwe) begin
                r_hi <= r_data;
            end
            if (w_ok & w_lowe) begin
                r_lo <= r_data;
            end
        end
    end

    // Register-file write data source select.
    always_comb begin
        w_rf_wdata = r_data;
        case (w_wbmux)
            2'b00:   w_rf_wdata = r_data;
            2'b01:   w_rf_wdata = r_hi;
            2'b10:   w_rf_wdata = r_lo;
            2'b11:   w_rf_wdata = cp0_rdata;
            default: w_rf_wdata = r_data;
        endcase
    end

    assign pipe4_allow_in = 1'b1;

    assign rf_we       = w_rf_we;
    assign rf_waddr    = w_dest;
    assign rf_wdata    = w_rf_wdata;
    assign cp0_we      = w_ok & w_cp0we;
    assign cp0_addr    = {w_cp0cs, w_cp0sel};
    assign cp0_wdata   = r_data;
    assign exc_commit  = w_exc;
    assign eret_commit = r_valid & w_eret & ~w_exc;
    assign exc_vec     = w_exc_vec;
    assign exc_pc      = w_pc;
    assign exc_bd      = w_btype;
    assign hi_out      = r_hi;
    assign lo_out      = r_lo;
    assign wb_dest     = w_rf_we ? w_dest : 5'd0;

`ifdef PIPE4_DEBUG_TRACE_EN
    assign debug_wb_pc       = r_valid ? w_pc : {DATA_W{1'b0}};
    assign debug_wb_rf_wen   = {4{w_rf_we}};
    assign debug_wb_rf_wnum  = w_dest;
    assign debug_wb_rf_wdata = w_rf_wdata;
`else
    assign debug_wb_pc       = {DATA_W{1'b0}};
    assign debug_wb_rf_wen   = 4'b0000;
    assign debug_wb_rf_wnum  = 5'd0;
    assign debug_wb_rf_wdata = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe4_wb.sv
// Directed self-checking bench for pipe4_wb: reset, RF write, HI/LO, CP0, exception/ERET commit.
module tb_pipe4_wb;

    logic        clk;
    logic        rst;
    logic        pipe4_valid_in;
    logic [60:0] pipe4_ctrl_info_in;
    logic [31:0] pipe4_data_info_in;
    logic        pipe4_allow_in;
    logic [31:0] cp0_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        cp0_we;
    logic [7:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        exc_commit;
    logic        eret_commit;
    logic [7:0]  exc_vec;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [4:0]  wb_dest;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int total;
    int bad;

    pipe4_wb dut (
        .clk                (clk),
        .rst                (rst),
        .pipe4_valid_in     (pipe4_valid_in),
        .pipe4_ctrl_info_in (pipe4_ctrl_info_in),
        .pipe4_data_info_in (pipe4_data_info_in),
        .pipe4_allow_in     (pipe4_allow_in),
        .cp0_rdata          (cp0_rdata),
        .rf_we              (rf_we),
        .rf_waddr           (rf_waddr),
        .rf_wdata           (rf_wdata),
        .cp0_we             (cp0_we),
        .cp0_addr           (cp0_addr),
        .cp0_wdata          (cp0_wdata),
        .exc_commit         (exc_commit),
        .eret_commit        (eret_commit),
        .exc_vec            (exc_vec),
        .exc_pc             (exc_pc),
        .exc_bd             (exc_bd),
        .hi_out             (hi_out),
        .lo_out             (lo_out),
        .wb_dest            (wb_dest),
        .debug_wb_pc        (debug_wb_pc),
        .debug_wb_rf_wen    (debug_wb_rf_wen),
        .debug_wb_rf_wnum   (debug_wb_rf_wnum),
        .debug_wb_rf_wdata  (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [60:0] mk_ctrl(
        input logic [8:0]  exop, input logic [31:0] pc, input logic [4:0] dest,
        input logic btype, input logic hiwe, input logic lowe, input logic cp0we,
        input logic [4:0] cs, input logic [2:0] sel, input logic [1:0] wbmux,
        input logic regwe);
        return {exop, pc, dest, btype, hiwe, lowe, cp0we, cs, sel, wbmux, regwe};
    endfunction

    // Offer one instruction for one cycle; outputs then reflect it until the next edge.
    task automatic issue(input logic [60:0] ctrl, input logic [31:0] data);
        pipe4_valid_in     = 1'b1;
        pipe4_ctrl_info_in = ctrl;
        pipe4_data_info_in = data;
        @(posedge clk);
        #1;
        pipe4_valid_in = 1'b0;
    endtask

    task automatic idle_cycle();
        pipe4_valid_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pipe4_valid_in = 1'b0;
        pipe4_ctrl_info_in = 61'd0;
        pipe4_data_info_in = 32'd0;
        cp0_rdata = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({rf_we, rf_waddr, rf_wdata, cp0_we, cp0_addr, cp0_wdata} !== 79'd0) begin
            bad++;
            $display("FAIL reset_rf_cp0 got=%h want=0", {rf_we, rf_waddr, rf_wdata, cp0_we, cp0_addr, cp0_wdata});
        end
        total++;
        if ({exc_commit, eret_commit, exc_vec, exc_pc, exc_bd, wb_dest} !== 48'd0) begin
            bad++;
            $display("FAIL reset_commit got=%h want=0", {exc_commit, eret_commit, exc_vec, exc_pc, exc_bd, wb_dest});
        end
        total++;
        if ({hi_out, lo_out} !== 64'd0) begin
            bad++;
            $display("FAIL reset_hilo got=%h want=0", {hi_out, lo_out});
        end
        total++;
        if (pipe4_allow_in !== 1'b1) begin
            bad++;
            $display("FAIL reset_allow got=%b want=1", pipe4_allow_in);
        end
    endtask

    task automatic test_addu();
        issue(mk_ctrl(9'h000, 32'h0000_1000, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'b00, 1'b1), 32'h1234_5678);
        total++;
        if ({rf_we, rf_waddr, rf_wdata, wb_dest} !== {1'b1, 5'd8, 32'h1234_5678, 5'd8}) begin
            bad++;
            $display("FAIL addu got we=%b a=%0d d=%h wbd=%0d want 1 8 12345678 8", rf_we, rf_waddr, rf_wdata, wb_dest);
        end
`ifdef PIPE4_DEBUG_TRACE_EN
        total++;
        if ({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} !== {32'h0000_1000, 4'hF, 5'd8, 32'h1234_5678}) begin
            bad++;
            $display("FAIL debug_trace got pc=%h wen=%h num=%0d d=%h", debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata);
        end
`else
        total++;
        if ({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} !== 73'd0) begin
            bad++;
            $display("FAIL debug_tied got pc=%h wen=%h num=%0d d=%h want 0", debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata);
        end
`endif
        idle_cycle();
        total++;
        if ({rf_we, wb_dest} !== 6'd0) begin
            bad++;
            $display("FAIL addu_idle got we=%b wbd=%0d want 0 0", rf_we, wb_dest);
        end
    endtask

    task automatic test_dest_zero();
        issue(mk_ctrl(9'h000, 32'h0000_1004, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'b00, 1'b1), 32'h0000_00FF);
        total++;
        if ({rf_we, wb_dest} !== 6'd0) begin
            bad++;
            $display("FAIL dest_zero got we=%b wbd=%0d want 0 0", rf_we, wb_dest);
        end
    endtask

    task automatic test_hilo();
        issue(mk_ctrl(9'h000, 32'h0000_1008, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 2'b00, 1'b0), 32'hDEAD_BEEF);
        total++;
        if (hi_out !== 32'd0) begin
            bad++;
            $display("FAIL mthi_pre got=%h want=00000000", hi_out);
        end
        issue(mk_ctrl(9'h000, 32'h0000_100C, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'b01, 1'b1), 32'h0000_0000);
        total++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL mfhi got we=%b a=%0d d=%h want 1 3 deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        total++;
        if ({hi_out, lo_out} !== {32'hDEAD_BEEF, 32'h0}) begin
            bad++;
            $display("FAIL mthi_hilo got hi=%h lo=%h want deadbeef 0", hi_out, lo_out);
        end
        // Both HI and LO take the same data; MFLO in the writer's own cycle still reads old LO.
        issue(mk_ctrl(9'h000, 32'h0000_1010, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 2'b10, 1'b1), 32'h55AA_33CC);
        total++;
        if (rf_wdata !== 32'h0) begin
            bad++;
            $display("FAIL self_read_lo got=%h want=00000000", rf_wdata);
        end
        issue(mk_ctrl(9'h000, 32'h0000_1014, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'b10, 1'b1), 32'h0);
        total++;
        if ({rf_wdata, hi_out, lo_out} !== {32'h55AA_33CC, 32'h55AA_33CC, 32'h55AA_33CC}) begin
            bad++;
            $display("FAIL hilo_both got d=%h hi=%h lo=%h want 55aa33cc x3", rf_wdata, hi_out, lo_out);
        end
    endtask

    task automatic test_cp0();
        issue(mk_ctrl(9'h000, 32'h0000_1018, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 3'd1, 2'b00, 1'b0), 32'h0000_ABCD);
        total++;
        if ({cp0_we, cp0_addr, cp0_wdata, rf_we} !== {1'b1, 8'h61, 32'h0000_ABCD, 1'b0}) begin
            bad++;
            $display("FAIL mtc0 got we=%b a=%h d=%h rfwe=%b want 1 61 0000abcd 0", cp0_we, cp0_addr, cp0_wdata, rf_we);
        end
        cp0_rdata = 32'hCAFE_F00D;
        issue(mk_ctrl(9'h000, 32'h0000_101C, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd14, 3'd0, 2'b11, 1'b1), 32'h0);
        total++;
        if ({rf_we, rf_waddr, rf_wdata, cp0_we} !== {1'b1, 5'd2, 32'hCAFE_F00D, 1'b0}) begin
            bad++;
            $display("FAIL mfc0 got we=%b a=%0d d=%h cp0we=%b want 1 2 cafef00d 0", rf_we, rf_waddr, rf_wdata, cp0_we);
        end
        cp0_rdata = 32'd0;
    endtask

    task automatic test_exception();
        issue(mk_ctrl(9'h004, 32'hBFC0_0100, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 3'd0, 2'b00, 1'b1), 32'h1111_1111);
        total++;
        if ({exc_commit, eret_commit, exc_vec, exc_pc, exc_bd} !== {1'b1, 1'b0, 8'h04, 32'hBFC0_0100, 1'b1}) begin
            bad++;
            $display("FAIL exc_commit got exc=%b eret=%b v=%h pc=%h bd=%b", exc_commit, eret_commit, exc_vec, exc_pc, exc_bd);
        end
        total++;
        if ({rf_we, wb_dest, cp0_we} !== 7'd0) begin
            bad++;
            $display("FAIL exc_nowrite got rfwe=%b wbd=%0d cp0we=%b want 0", rf_we, wb_dest, cp0_we);
        end
        idle_cycle();
        total++;
        if ({exc_commit, hi_out} !== {1'b0, 32'h55AA_33CC}) begin
            bad++;
            $display("FAIL exc_after got exc=%b hi=%h want 0 55aa33cc", exc_commit, hi_out);
        end
    endtask

    task automatic test_eret();
        issue(mk_ctrl(9'h100, 32'h0000_2000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'b00, 1'b0), 32'h0);
        total++;
        if ({eret_commit, exc_commit} !== 2'b10) begin
            bad++;
            $display("FAIL eret got eret=%b exc=%b want 1 0", eret_commit, exc_commit);
        end
        idle_cycle();
        total++;
        if ({eret_commit, exc_commit} !== 2'b00) begin
            bad++;
            $display("FAIL eret_pulse got eret=%b exc=%b want 0 0", eret_commit, exc_commit);
        end
        issue(mk_ctrl(9'h101, 32'h0000_2004, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 2'b00, 1'b0), 32'h0);
        total++;
        if ({eret_commit, exc_commit, exc_vec} !== {1'b0, 1'b1, 8'h01}) begin
            bad++;
            $display("FAIL eret_exc_prio got eret=%b exc=%b v=%h want 0 1 01", eret_commit, exc_commit, exc_vec);
        end
    endtask

    task automatic test_reset_midstream();
        issue(mk_ctrl(9'h000, 32'h0000_3000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 2'b00, 1'b0), 32'h7777_7777);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({lo_out, hi_out, rf_we, cp0_we, exc_commit} !== 67'd0) begin
            bad++;
            $display("FAIL reset_mid got lo=%h hi=%h rfwe=%b cp0we=%b exc=%b want 0", lo_out, hi_out, rf_we, cp0_we, exc_commit);
        end
        idle_cycle();
        total++;
        if (lo_out !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_hold got lo=%h want 0", lo_out);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_addu();
        test_dest_zero();
        test_hilo();
        test_cp0();
        test_exception();
        test_eret();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe4_wb.md
Name: pipe4_wb

Overview:
- Write-back stage (PIPE4), directly downstream of the memory stage (PIPE3).
- Registers PIPE3's 61-bit control bundle and 32-bit result under the valid/allow handshake.
- Owns the HI/LO registers, drives the register-file write port and the CP0 write/exception-commit interface.
- Supplies the WB-stage forwarding destination to the hazard logic.

Parameters:
- CTRL_W, 61, width of pipe4_ctrl_info_in.
- DATA_W, 32, width of pipe4_data_info_in and all datapaths.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pipe4_valid_in  in  1  PIPE3 offers an instruction.
- pipe4_ctrl_info_in  in  61  fields: exop 60-52 (bit 60 = eret, 59-52 = exception vector), pc 51-20, dest 19-15, btype 14, hiwe 13, lowe 12, cp0we 11, cp0cs 10-6, cp0sel 5-3, wbmux 2-1, regwe 0.
- pipe4_data_info_in  in  32  result (ALU or load data).
- pipe4_allow_in  out  1  PIPE4 accepts a new instruction this cycle.
- cp0_rdata  in  32  CP0 read data for {cp0cs, cp0sel}.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- cp0_we  out  1  CP0 write strobe.
- cp0_addr  out  8  {cp0cs, cp0sel} of the registered instruction.
- cp0_wdata  out  32  CP0 write data.
- exc_commit  out  1  exception commit pulse.
- eret_commit  out  1  ERET commit pulse.
- exc_vec  out  8  registered exop[7:0].
- exc_pc  out  32  registered pc.
- exc_bd  out  1  registered btype (delay-slot flag).
- hi_out  out  32  current HI value.
- lo_out  out  32  current LO value.
- wb_dest  out  5  forwarding destination; 0 when no write.
- debug_wb_pc  out  32  trace port.
- debug_wb_rf_wen  out  4  trace port.
- debug_wb_rf_wnum  out  5  trace port.
- debug_wb_rf_wdata  out  32  trace port.

Behaviour:
- State: valid bit v, ctrl_r[60:0], data_r[31:0], HI[31:0], LO[31:0].
- pipe4_allow_in = 1 at all times: rdy_go = 1 and the stage is the pipeline sink.
- On every clk with rst = 0:
  - v <= pipe4_valid_in.
  - ctrl_r and data_r load only when pipe4_valid_in = 1; otherwise they hold.
- Reset (rst = 1 at clk):
  - v, HI, LO, ctrl_r and data_r all clear to 0.
  - All outputs are therefore 0 in the cycle after reset.
  - Reset mid-stream discards the held instruction with no write.
- Qualifiers:
  - ok = v & ~|ctrl_r[59:52] & ~ctrl_r[60].
  - An excepting or ERET instruction performs no architectural writes except the CP0 commit.
- rf_we = ok & regwe & (dest != 0). rf_waddr = dest.
- rf_wdata is selected by wbmux: 00 -> data_r, 01 -> HI, 10 -> LO, 11 -> cp0_rdata.
- HI/LO update:
  - HI <= data_r at clk when ok & hiwe; LO <= data_r at clk when ok & lowe.
  - Both may be set in the same cycle and both take data_r.
  - A read of HI/LO by the registered instruction itself (wbmux 01/10) returns the pre-write value.
  - Back-to-back MTHI then MFHI is correct: the write lands at the boundary.
- cp0_we = ok & cp0we. cp0_wdata = data_r.
- Commit pulses:
  - exc_commit = v & |ctrl_r[59:52]. It is one cycle per instruction because v is re-sampled each cycle.
  - eret_commit = v & ctrl_r[60] & ~exc_commit. Exception has priority if both are set.
- Upstream must flush its stages in the same cycle exc_commit or eret_commit is high; PIPE4 does not squash its own next input.
- wb_dest = rf_we ? dest : 5'd0.
- All outputs are combinational from the registered state plus cp0_rdata, so commit latency is 1 cycle from PIPE3 handoff.

Optional Feature:
- Macro: PIPE4_DEBUG_TRACE_EN.
- Defined: debug_wb_pc = pc when v else 0; debug_wb_rf_wen = {4{rf_we}}; debug_wb_rf_wnum = rf_waddr; debug_wb_rf_wdata = rf_wdata.
- Undefined: all four debug ports are tied to 0 and no extra logic is generated.

Test Plan:
- Reset then idle -> every output is 0, hi_out/lo_out = 0, pipe4_allow_in = 1.
- ADDU: valid = 1, dest = 5'd8, regwe = 1, wbmux = 00, data = 32'h1234_5678 -> next cycle rf_we = 1, rf_waddr = 8, rf_wdata = 32'h1234_5678, wb_dest = 8.
- dest = 0 with regwe = 1 -> rf_we = 0 and wb_dest = 0.
- MTHI data 32'hDEAD_BEEF (hiwe = 1), then MFHI dest = 5'd3 (wbmux = 01) on the next cycle -> rf_wdata = 32'hDEAD_BEEF. LO is unchanged at 0.
- Instruction with exop = 9'h004, pc = 32'hBFC0_0100, btype = 1, regwe = 1, hiwe = 1 -> exc_commit = 1 for exactly one cycle, exc_vec = 8'h04, exc_pc = 32'hBFC0_0100, exc_bd = 1; rf_we = 0 and HI is unchanged.
- ERET (exop = 9'h100) -> eret_commit = 1 for one cycle, exc_commit = 0. The same with exop = 9'h101 -> exc_commit = 1 and eret_commit = 0.
- Assert rst while a valid MTLO is registered -> LO = 0 next cycle and no rf_we or cp0_we pulse.
